fir_result_fifo: RTL and testbench

- Buffers filter results downstream of the FIR accelerator, so software never misses a result between APB reads.
- Captures each result on its valid strobe and sign-extends it to 32 bits.
- Exposes a pop-on-read FIFO head plus level, flag and threshold-interrupt status to the APB register slave.
- Sits between the genericfir result/valid outputs and the apb_acc read mux.

---
 rtl/fir_buf_pkg.sv | 16 +
 rtl/fir_buf_mem.sv | 26 ++
 rtl/fir_result_fifo.sv | 110 +++++++++++
 tb/tb_fir_result_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_buf_pkg.sv
// Shared constants and helpers for the FIR result buffer and its APB register map.
package fir_buf_pkg;

    localparam int FIR_IW = 12;
    localparam int FIR_OW = 2 * FIR_IW + 7;
    localparam int APB_DW = 32;

    localparam logic [7:0] FIFO_DATA_OFS   = 8'h18;
    localparam logic [7:0] FIFO_STATUS_OFS = 8'h1C;
    localparam logic [7:0] FIFO_THRESH_OFS = 8'h20;

    function automatic logic [APB_DW-1:0] sext_result(input logic [FIR_OW-1:0] result);
        return {{(APB_DW - FIR_OW){result[FIR_OW-1]}}, result};
    endfunction

endpackage

// File: rtl/fir_buf_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
// Kept separate so it can later be swapped for a memory macro.
module fir_buf_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 31,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             HCLK,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_result_fifo.sv
// Pop-on-read FIFO for FIR results with level, full/empty, sticky overflow and threshold irq.
module fir_result_fifo
    import fir_buf_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int IN_WIDTH  = FIR_OW,
    parameter int OUT_WIDTH = APB_DW,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 clear_i,
    input  logic [IN_WIDTH-1:0]  sample_i,
    input  logic                 sample_valid_i,
    input  logic                 pop_i,
    input  logic [LW-1:0]        thresh_i,
    input  logic                 ovf_clr_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic [LW-1:0]        level_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 overflow_o,
    output logic                 irq_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       count;
    logic [LW-1:0]       count_next;
    logic                push_en;
    logic                pop_en;
    logic                ovf_evt;
    logic [IN_WIDTH-1:0] head;
    logic [OUT_WIDTH-1:0] head_ext;

    assign empty_o = (count == '0);
    assign full_o  = (count == LW'(DEPTH));
    assign level_o = count;

    // A pop frees the slot being written when full; a pop on empty never bypasses.
    assign push_en = sample_valid_i & (~full_o | pop_i);
    assign pop_en  = pop_i & ~empty_o;
    assign ovf_evt = sample_valid_i & full_o & ~pop_i;

    always_comb begin
        count_next = count;
        if (push_en && !pop_en) begin
            count_next = count + LW'(1);
        end else if (!push_en && pop_en) begin
            count_next = count - LW'(1);
        end
    end

    // irq is derived from the registered level, so it trails level_o by one cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            irq_o      <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            if (ovf_evt) begin
                overflow_o <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_o <= 1'b0;
            end
            irq_o <= (thresh_i != '0) && (count >= thresh_i);
        end
    end

    fir_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (IN_WIDTH)
    ) u_mem (
        .HCLK    (HCLK),
        .wr_en   (push_en & ~clear_i),
        .wr_addr (wr_ptr),
        .wr_data (sample_i),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    generate
        if (IN_WIDTH == FIR_OW && OUT_WIDTH == APB_DW) begin : g_pkg_sext
            assign head_ext = sext_result(head);
        end else begin : g_cast_sext
            assign head_ext = OUT_WIDTH'($signed(head));
        end
    endgenerate

    // Gating by empty keeps never-written memory off the bus.
    assign data_o = empty_o ? '0 : head_ext;

endmodule

// File: tb/tb_fir_result_fifo.sv
// Directed, table-driven bench for fir_result_fifo with hand sequences for multi-cycle corners.
module tb_fir_result_fifo;

    logic        HCLK;
    logic        HRESET;
    logic        clear_i;
    logic [30:0] sample_i;
    logic        sample_valid_i;
    logic        pop_i;
    logic [3:0]  thresh_i;
    logic        ovf_clr_i;
    logic [31:0] data_o;
    logic [3:0]  level_o;
    logic        empty_o;
    logic        full_o;
    logic        overflow_o;
    logic        irq_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        push;
        logic [30:0] sample;
        logic        pop;
        logic        clr;
        logic [31:0] exp_data;
        logic [3:0]  exp_level;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    vec_t vecs [10];

    fir_result_fifo dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .clear_i        (clear_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .pop_i          (pop_i),
        .thresh_i       (thresh_i),
        .ovf_clr_i      (ovf_clr_i),
        .data_o         (data_o),
        .level_o        (level_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .overflow_o     (overflow_o),
        .irq_o          (irq_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One clock edge with the given strobes; all single-cycle strobes drop afterwards.
    task automatic step(input logic push, input logic [30:0] smp, input logic pop);
        sample_valid_i = push;
        sample_i       = smp;
        pop_i          = pop;
        @(posedge HCLK);
        #1;
        sample_valid_i = 1'b0;
        pop_i          = 1'b0;
        clear_i        = 1'b0;
        ovf_clr_i      = 1'b0;
    endtask

    function automatic logic [31:0] sext(input logic [30:0] v);
        return {v[30], v};
    endfunction

    logic [30:0] model [$];
    int          pushed;
    int          popped;
    int          cycles;
    logic        do_push;
    logic        do_pop;
    logic [30:0] val;

    initial begin
        vecs[0] = '{1'b1, 31'h7FFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 4'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 31'h00000005, 1'b0, 1'b0, 32'hFFFFFFFF, 4'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 31'h40000000, 1'b0, 1'b0, 32'hFFFFFFFF, 4'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 31'h00000000, 1'b1, 1'b0, 32'h00000005, 4'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 31'h00000000, 1'b1, 1'b0, 32'hC0000000, 4'd1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 31'h04000000, 1'b1, 1'b0, 32'h04000000, 4'd1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 31'h00000000, 1'b1, 1'b0, 32'h00000000, 4'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 31'h00000000, 1'b1, 1'b0, 32'h00000000, 4'd0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 31'h000000AB, 1'b1, 1'b0, 32'h000000AB, 4'd1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 31'h00000011, 1'b0, 1'b1, 32'h00000000, 4'd0, 1'b1, 1'b0};

        HRESET         = 1'b1;
        clear_i        = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        pop_i          = 1'b0;
        thresh_i       = '0;
        ovf_clr_i      = 1'b0;
        #12;
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        for (int i = 0; i < 10; i++) begin
            clear_i = vecs[i].clr;
            step(vecs[i].push, vecs[i].sample, vecs[i].pop);
            check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
            check($sformatf("vec%0d_level", i), 32'(level_o), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i), 32'(full_o), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d_ovf", i), 32'(overflow_o), 32'd0);
        end

        // Asynchronous reset in the middle of a fill.
        step(1'b1, 31'h1, 1'b0);
        step(1'b1, 31'h2, 1'b0);
        step(1'b1, 31'h3, 1'b0);
        check("midfill_level", 32'(level_o), 32'd3);
        #2;
        HRESET = 1'b1;
        #1;
        check("arst_level", 32'(level_o), 32'd0);
        check("arst_empty", 32'(empty_o), 32'd1);
        check("arst_data", data_o, 32'd0);
        check("arst_ovf", 32'(overflow_o), 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        step(1'b1, 31'h0AB, 1'b0);
        check("post_rst_data", data_o, 32'h000000AB);
        check("post_rst_level", 32'(level_o), 32'd1);

        // Fill past full, exercise overflow set/clear priority, then push+pop while full.
        clear_i = 1'b1;
        step(1'b0, '0, 1'b0);
        for (int k = 1; k <= 8; k++) step(1'b1, 31'(k * 16), 1'b0);
        check("fill_full", 32'(full_o), 32'd1);
        check("fill_level", 32'(level_o), 32'd8);
        check("fill_ovf", 32'(overflow_o), 32'd0);
        step(1'b1, 31'h90, 1'b0);
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_level", 32'(level_o), 32'd8);
        ovf_clr_i = 1'b1;
        step(1'b1, 31'h91, 1'b0);
        check("ovf_set_wins", 32'(overflow_o), 32'd1);
        ovf_clr_i = 1'b1;
        step(1'b0, '0, 1'b0);
        check("ovf_cleared", 32'(overflow_o), 32'd0);
        check("full_head", data_o, 32'h10);
        step(1'b1, 31'h123, 1'b1);
        check("fullpp_level", 32'(level_o), 32'd8);
        check("fullpp_ovf", 32'(overflow_o), 32'd0);
        for (int k = 2; k <= 8; k++) begin
            check($sformatf("drain%0d", k), data_o, 32'(k * 16));
            step(1'b0, '0, 1'b1);
        end
        check("drain_new", data_o, 32'h123);
        step(1'b0, '0, 1'b1);
        check("drain_empty", 32'(empty_o), 32'd1);

        // Threshold interrupt, which trails the level by one cycle.
        clear_i  = 1'b1;
        step(1'b0, '0, 1'b0);
        thresh_i = 4'd3;
        step(1'b1, 31'hA1, 1'b0);
        step(1'b1, 31'hA2, 1'b0);
        step(1'b0, '0, 1'b0);
        check("irq_two", 32'(irq_o), 32'd0);
        step(1'b1, 31'hA3, 1'b0);
        check("irq_lag", 32'(irq_o), 32'd0);
        step(1'b0, '0, 1'b0);
        check("irq_three", 32'(irq_o), 32'd1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("irq_after_pop", 32'(irq_o), 32'd0);
        thresh_i = 4'd0;
        for (int k = 0; k < 6; k++) step(1'b1, 31'(k), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("irq_thr0_full", 32'(full_o), 32'd1);
        check("irq_thr0", 32'(irq_o), 32'd0);
        thresh_i = 4'd9;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("irq_thr9", 32'(irq_o), 32'd0);
        thresh_i = 4'd8;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("irq_thr8", 32'(irq_o), 32'd1);
        clear_i = 1'b1;
        step(1'b0, '0, 1'b0);
        check("irq_clr_level", 32'(level_o), 32'd0);
        check("irq_clr", 32'(irq_o), 32'd0);
        thresh_i = 4'd0;

        // Wrap-around against a queue model with random gaps.
        pushed = 0;
        popped = 0;
        cycles = 0;
        while ((pushed < 20 || popped < 20) && cycles < 400) begin
            do_push = (pushed < 20) && (model.size() < 8) && ($urandom_range(0, 2) != 0);
            do_pop  = (model.size() > 0) && ($urandom_range(0, 2) != 0);
            val     = 31'($urandom);
            if (do_pop) begin
                check($sformatf("wrap_data%0d", popped), data_o, sext(model[0]));
                void'(model.pop_front());
                popped++;
            end
            step(do_push, val, do_pop);
            if (do_push) begin
                model.push_back(val);
                pushed++;
            end
            check("wrap_level", 32'(level_o), 32'(model.size()));
            cycles++;
        end
        check("wrap_done", 32'(popped), 32'd20);
        check("wrap_empty", 32'(empty_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
